// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressable DEPTH x 32 data memory behind a valid/ready
// request port. Handles byte/half/word stores with lane masking and
// sign/zero-extended loads, and inserts WAIT_CYCLES wait states between
// accept and access.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN. When it is defined,
// misaligned half/word accesses are rejected. When it is undefined, the
// low address bits are ignored for the access size.
module dmem_ctrl #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH];

    logic        cap_we;
    logic [1:0]  cap_size;
    logic        cap_unsigned;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic        sel_we;
    logic [1:0]  sel_size;
    logic        sel_unsigned;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    logic          accept;
    logic          do_access;
    logic          acc_err;
    logic          misaligned;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [7:0]    byte_val;
    logic [15:0]   half_val;
    logic [31:0]   load_data;
    logic [3:0]    wmask;
    logic [31:0]   wword;

    assign accept = req_valid && req_ready;

    // The access uses live request fields when it happens on the accept edge,
    // and the captured copy when it happens at the end of the wait phase.
    always_comb begin
        if (state == WAIT) begin
            sel_we       = cap_we;
            sel_size     = cap_size;
            sel_unsigned = cap_unsigned;
            sel_addr     = cap_addr;
            sel_wdata    = cap_wdata;
        end else begin
            sel_we       = req_we;
            sel_size     = req_size;
            sel_unsigned = req_unsigned;
            sel_addr     = req_addr;
            sel_wdata    = req_wdata;
        end
    end

    // Decide when the access happens, then decode errors, store lanes and load data.
    always_comb begin
        if (WAIT_CYCLES == 0) do_access = accept;
        else                  do_access = (state == WAIT) && (cnt == 4'd1);

`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned = ((sel_size == 2'b01) && sel_addr[0]) ||
                     ((sel_size == 2'b10) && (sel_addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        acc_err = ((sel_addr >> (AW + 2)) != 32'd0) || (sel_size == 2'b11) || misaligned;

        word_idx = sel_addr[AW+1:2];
        rd_word  = mem[word_idx];
        byte_val = 8'(rd_word >> {sel_addr[1:0], 3'b000});
        half_val = 16'(rd_word >> {sel_addr[1], 4'b0000});

        case (sel_size)
            2'b00: begin
                load_data = sel_unsigned ? {24'd0, byte_val} : {{24{byte_val[7]}}, byte_val};
                wmask     = 4'b0001 << sel_addr[1:0];
                wword     = {4{sel_wdata[7:0]}};
            end
            2'b01: begin
                load_data = sel_unsigned ? {16'd0, half_val} : {{16{half_val[15]}}, half_val};
                wmask     = sel_addr[1] ? 4'b1100 : 4'b0011;
                wword     = {2{sel_wdata[15:0]}};
            end
            default: begin
                load_data = rd_word;
                wmask     = 4'b1111;
                wword     = sel_wdata;
            end
        endcase
    end

    // Storage: cleared on reset, lane-masked write on an error-free store access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_access && sel_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem[word_idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= '0;
            cap_we       <= 1'b0;
            cap_size     <= '0;
            cap_unsigned <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
        end else begin
            rsp_valid <= do_access;
            if (do_access) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || sel_we) ? 32'd0 : load_data;
            end
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        cap_we       <= req_we;
                        cap_size     <= req_size;
                        cap_unsigned <= req_unsigned;
                        cap_addr     <= req_addr;
                        cap_wdata    <= req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state     <= RESP;
                            req_ready <= 1'b1;
                        end else begin
                            state     <= WAIT;
                            cnt       <= 4'(WAIT_CYCLES);
                            req_ready <= 1'b0;
                        end
                    end else begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl with DEPTH = 64 and WAIT_CYCLES = 3.
module tb_dmem_ctrl;

    localparam int WAITS = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    dmem_ctrl #(.DEPTH(64), .WAIT_CYCLES(WAITS)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Drive one request, hold it until accepted, and queue its expected response.
    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        output int waits);
        exp_t e;
        waits = 0;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        while (!req_ready && waits < 64) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) begin
            check_eq("ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
        end else begin
            e.rdata   = exp_rdata;
            e.err     = exp_err;
            e.acc_cyc = cyc + 1;
            q.push_back(e);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("drain", 32'(q.size()), 32'd0);
    endtask

    // Response monitor: compare each strobe against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    check_eq("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check_eq("rdata", rsp_rdata, e.rdata);
                    check_eq("err", {31'd0, rsp_err}, {31'd0, e.err});
                    check_eq("latency", 32'(cyc - e.acc_cyc), 32'(WAITS));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_err", {31'd0, rsp_err}, 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'd0);
        reset = 1'b0;

        // Every word reads back zero after reset.
        for (int a = 0; a < 64; a++) send(1'b0, 2'b10, 1'b0, 32'(a * 4), 32'd0, 32'd0, 1'b0, w);

        // Byte merge into a word, signed/unsigned byte and half loads.
        send(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 32'd0, 1'b0, w);
        send(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA, 32'd0, 1'b0, w);
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h11AA_3344, 1'b0, w);
        send(1'b0, 2'b00, 1'b0, 32'h12, 32'd0, 32'hFFFF_FFAA, 1'b0, w);
        send(1'b0, 2'b00, 1'b1, 32'h12, 32'd0, 32'h0000_00AA, 1'b0, w);
        send(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 32'h0000_0011, 1'b0, w);
        send(1'b0, 2'b01, 1'b0, 32'h10, 32'd0, 32'h0000_3344, 1'b0, w);

        // Upper half store leaves the lower bytes intact.
        send(1'b1, 2'b10, 1'b0, 32'h20, 32'h5566_7788, 32'd0, 1'b0, w);
        send(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_8001, 32'd0, 1'b0, w);
        send(1'b0, 2'b01, 1'b0, 32'h22, 32'd0, 32'hFFFF_8001, 1'b0, w);
        send(1'b0, 2'b01, 1'b1, 32'h22, 32'd0, 32'h0000_8001, 1'b0, w);
        send(1'b0, 2'b00, 1'b1, 32'h20, 32'd0, 32'h0000_0088, 1'b0, w);
        send(1'b0, 2'b00, 1'b1, 32'h21, 32'd0, 32'h0000_0077, 1'b0, w);
        send(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'h8001_7788, 1'b0, w);

        // Out of range, reserved size.
        send(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'd0, 1'b1, w);
        send(1'b0, 2'b10, 1'b0, 32'h00, 32'd0, 32'd0, 1'b0, w);
        send(1'b0, 2'b10, 1'b0, 32'h104, 32'd0, 32'd0, 1'b1, w);
        send(1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 32'd0, 1'b1, w);

        // Misaligned accesses.
        send(1'b1, 2'b10, 1'b0, 32'h04, 32'hCAFE_F00D, 32'd0, 1'b0, w);
`ifdef DMEM_MISALIGN_TRAP_EN
        send(1'b0, 2'b10, 1'b0, 32'h06, 32'd0, 32'd0, 1'b1, w);
        send(1'b0, 2'b01, 1'b1, 32'h13, 32'd0, 32'd0, 1'b1, w);
        send(1'b1, 2'b01, 1'b0, 32'h25, 32'h0000_BEEF, 32'd0, 1'b1, w);
        send(1'b0, 2'b10, 1'b0, 32'h24, 32'd0, 32'd0, 1'b0, w);
`else
        send(1'b0, 2'b10, 1'b0, 32'h06, 32'd0, 32'hCAFE_F00D, 1'b0, w);
        send(1'b0, 2'b01, 1'b1, 32'h13, 32'd0, 32'h0000_11AA, 1'b0, w);
        send(1'b1, 2'b01, 1'b0, 32'h25, 32'h0000_BEEF, 32'd0, 1'b0, w);
        send(1'b0, 2'b10, 1'b0, 32'h24, 32'd0, 32'h0000_BEEF, 1'b0, w);
`endif

        // Back-to-back requests: ready stays low for the wait phase after each accept.
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h11AA_3344, 1'b0, w);
        for (int k = 0; k < 4; k++) begin
            send(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'h8001_7788, 1'b0, w);
            check_eq("ready_low_cycles", 32'(w), 32'(WAITS));
        end
        drain();

        // Reset in the middle of a store's wait phase drops it.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h08;
        req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("wait_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        end
        reset = 1'b0;
        repeat (WAITS + 2) begin
            @(negedge clk);
            check_eq("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
        end
        send(1'b0, 2'b10, 1'b0, 32'h08, 32'd0, 32'd0, 1'b0, w);
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'd0, 1'b0, w);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised byte-addressable data memory for the RV32I core's load/store path, successor to the fixed 64-word word-indexed data memory. It accepts one request per cycle over a valid/ready handshake, supports byte/half/word stores with lane masking and sign/zero-extended loads, and inserts a configurable number of wait states. It also reports out-of-range and misaligned accesses.

## Interface
Parameters:
- DEPTH, 64, memory size in 32-bit words; power of two, ≥ 4.
- WAIT_CYCLES, 0, extra cycles between request accept and memory access; 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1 and sign-extends when 0; ignored for stores and word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response strobe; no backpressure.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access rejected; qualified by rsp_valid.

## Operation
- Storage is DEPTH × 32 bits. The word index is req_addr[AW+1:2], where AW = clog2(DEPTH). Byte lane is req_addr[1:0]. Half lane is req_addr[1].
- A request is accepted on a rising edge with req_valid && req_ready. All request fields are captured into internal registers, so inputs may change after accept.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: req_ready = 1.
    - On accept with WAIT_CYCLES = 0: perform the access on the accept edge and go to RESP.
    - On accept with WAIT_CYCLES > 0: load the counter with WAIT_CYCLES and go to WAIT.
  - WAIT: req_ready = 0. The counter decrements each edge. When it reaches 1, perform the access on that edge and go to RESP.
  - RESP: rsp_valid = 1 and req_ready = 1. A new accept in RESP behaves exactly as an accept in IDLE. With no accept, go to IDLE.
- Error conditions set rsp_err = 1, suppress the write, and force rsp_rdata = 0:
  - req_addr ≥ 4·DEPTH;
  - req_size = 11;
  - misalignment (half with addr[0] = 1, word with addr[1:0] ≠ 0); subject to the Configuration section.
- Store: only the addressed lanes change (1, 2 or 4 lanes). Other bytes of the word are preserved.
- Load: select the addressed byte or half, then extend to 32 bits per req_unsigned. A word load returns the full word.
- A store completes with rsp_valid = 1, rsp_err = 0 and rsp_rdata = 0.

## Timing
- Reset asserted (asynchronous) gives:
  - state = IDLE and counter = 0;
  - req_ready = 1;
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0;
  - all DEPTH words cleared to 0.
- Reset during WAIT or RESP drops the pending request. No write occurs and no response is produced.
- Latency: rsp_valid is high in the cycle following edge E + WAIT_CYCLES, where E is the accept edge.
- Throughput is 1 request/cycle at WAIT_CYCLES = 0, and 1 per (WAIT_CYCLES + 1) cycles otherwise.
- Read-after-write: a load accepted in the cycle in which the preceding store's rsp_valid is high observes the stored data.
- rsp_rdata and rsp_err are registered and hold their value outside rsp_valid. They are meaningful only when rsp_valid = 1.

## Configuration
- DMEM_MISALIGN_TRAP_EN:
  - Defined: misaligned half/word accesses are errors (rsp_err = 1, no write, rdata = 0).
  - Undefined: the low address bits are ignored for the access size (half uses addr & ~1, word uses addr & ~3), the access proceeds normally, and rsp_err is raised only for out-of-range or size 11.

## Test plan
- Reset, then word load of each address 0x00..0xFC (DEPTH = 64) → every rsp_rdata = 0x00000000, rsp_err = 0.
- Word store 0x11223344 @0x10, byte store 0xAA @0x12, word load @0x10 → 0x11AA3344; load byte signed @0x12 → 0xFFFFFFAA; load byte unsigned @0x12 → 0x000000AA.
- Half store 0x8001 @0x22, half load signed @0x22 → 0xFFFF8001, half load unsigned → 0x00008001; bytes @0x20/0x21 unchanged.
- Word store @0x100 (DEPTH = 64) → rsp_err = 1 and memory unchanged. Word load @0x06 → rsp_err = 1 with TRAP_EN defined; without TRAP_EN it returns the word @0x04 with rsp_err = 0.
- WAIT_CYCLES = 3: back-to-back req_valid → req_ready low for 3 cycles after each accept, rsp_valid exactly 3 cycles after each accept edge, one response per accepted request.
- Assert reset during WAIT of a store @0x08 → no rsp_valid, and a later load @0x08 returns 0.
